// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Contents:
//   pc_state_e  - sequencer FSM state (IDLE/FETCH/HALT)
//   redirect_e  - redirect kind, ordered by priority (NONE < BRANCH < JUMP < TRAP)
//   DEF_*       - default reset vector, trap vector and instruction size
//   misaligned  - true when an address is not 4-byte aligned
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } pc_state_e;

  // The numeric order is the priority order; comparisons on this enum rely on it.
  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_BRANCH = 2'd1,
    RD_JUMP   = 2'd2,
    RD_TRAP   = 2'd3
  } redirect_e;

  localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
  localparam logic [63:0] DEF_TRAP_VECTOR  = 64'h100;
  localparam int          DEF_INSTR_BYTES  = 4;

  function automatic logic misaligned(input logic [63:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between the sequencer and instruction memory.
// Handshake: a fetch is outstanding while imem_req_o=1; it completes in the
// cycle where imem_ready_i=1, and the sequencer raises instr_valid_o in that
// same cycle. imem_addr_o is only meaningful while imem_req_o=1.
// Signals:
//   imem_req_o    - fetch request (sequencer -> memory)
//   imem_addr_o   - fetch address (sequencer -> memory)
//   imem_ready_i  - memory accepts/returns the fetch (memory -> sequencer)
//   instr_valid_o - fetch completes this cycle (sequencer -> consumers)
interface pc_sequencer_if;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_ready_i;
  logic        instr_valid_o;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    output instr_valid_o,
    input  imem_ready_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    input  instr_valid_o,
    output imem_ready_i
  );
endinterface

// File: rtl/pc_redirect_latch.sv
// Pending redirect register. Merges the current-cycle redirect with the held
// one, keeping only the highest-priority kind (a later pulse of equal kind
// replaces the target). The merged value is presented combinationally so the
// sequencer can apply it in the same cycle; applying it empties the register.
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset
//   apply_i       - merged redirect is consumed this cycle
//   cur_kind_i    - highest-priority redirect pulsed this cycle
//   cur_tgt_i     - target belonging to cur_kind_i
//   sel_kind_o    - merged (pending + current) redirect kind
//   sel_tgt_o     - merged redirect target
module pc_redirect_latch
  import pc_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        apply_i,
  input  redirect_e   cur_kind_i,
  input  logic [63:0] cur_tgt_i,
  output redirect_e   sel_kind_o,
  output logic [63:0] sel_tgt_o
);

  redirect_e   pend_kind_q;
  logic [63:0] pend_tgt_q;

  always_comb begin
    sel_kind_o = pend_kind_q;
    sel_tgt_o  = pend_tgt_q;
    if (cur_kind_i != RD_NONE && cur_kind_i >= pend_kind_q) begin
      sel_kind_o = cur_kind_i;
      sel_tgt_o  = cur_tgt_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || apply_i) begin
      pend_kind_q <= RD_NONE;
      pend_tgt_q  <= '0;
    end else begin
      pend_kind_q <= sel_kind_o;
      pend_tgt_q  <= sel_tgt_o;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: chooses the next PC for an external PC register,
// issues instruction fetches, and handles stalls, redirects and halt.
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   imem                    - fetch handshake (pc_sequencer_if.master)
//   pc_i                    - current PC from the external register
//   pc_next_o               - value loaded into the PC register every cycle
//   branch_i/branch_target_i, jump_i/jump_target_i, trap_i - redirect pulses
//   halt_i, resume_i        - enter / leave HALT
//   state_o                 - FSM state (debug)
//   misalign_o              - misaligned jump/branch target was applied
//   fetch_count_o           - saturating count of completed fetches
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [63:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
  parameter int          INSTR_BYTES  = DEF_INSTR_BYTES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pc_sequencer_if.master        imem,
  input  logic [63:0]           pc_i,
  output logic [63:0]           pc_next_o,
  input  logic                  branch_i,
  input  logic [63:0]           branch_target_i,
  input  logic                  jump_i,
  input  logic [63:0]           jump_target_i,
  input  logic                  trap_i,
  input  logic                  halt_i,
  input  logic                  resume_i,
  output logic [1:0]            state_o,
  output logic                  misalign_o,
  output logic [31:0]           fetch_count_o
);

  pc_state_e   state_q;
  pc_state_e   cur_st;
  logic        halt_pend_q;
  logic [31:0] fetch_cnt_q;
  redirect_e   cur_kind;
  logic [63:0] cur_tgt;
  redirect_e   sel_kind;
  logic [63:0] sel_tgt;
  logic        apply;
  logic        accept;

  // Encoding 3 cannot be reached, but if it ever appears it behaves as IDLE.
  always_comb begin
    case (state_q)
      ST_FETCH: cur_st = ST_FETCH;
      ST_HALT:  cur_st = ST_HALT;
      default:  cur_st = ST_IDLE;
    endcase
  end

  // Highest-priority redirect pulsed this cycle; a trap always targets TRAP_VECTOR.
  always_comb begin
    cur_kind = RD_NONE;
    cur_tgt  = '0;
    if (trap_i) begin
      cur_kind = RD_TRAP;
      cur_tgt  = TRAP_VECTOR;
    end else if (jump_i) begin
      cur_kind = RD_JUMP;
      cur_tgt  = jump_target_i;
    end else if (branch_i) begin
      cur_kind = RD_BRANCH;
      cur_tgt  = branch_target_i;
    end
  end

  pc_redirect_latch u_redirect_latch (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .apply_i    (apply),
    .cur_kind_i (cur_kind),
    .cur_tgt_i  (cur_tgt),
    .sel_kind_o (sel_kind),
    .sel_tgt_o  (sel_tgt)
  );

  assign accept = !rst_i && cur_st == ST_FETCH && imem.imem_ready_i;
  assign apply  = accept;

  always_comb begin
    pc_next_o          = pc_i;
    imem.imem_req_o    = 1'b0;
    imem.imem_addr_o   = pc_i;
    imem.instr_valid_o = 1'b0;
    misalign_o         = 1'b0;
    case (cur_st)
      ST_IDLE: pc_next_o = RESET_VECTOR;
      ST_FETCH: begin
        imem.imem_req_o = 1'b1;
        if (imem.imem_ready_i) begin
          imem.instr_valid_o = 1'b1;
          case (sel_kind)
            RD_NONE: pc_next_o = pc_i + 64'(INSTR_BYTES);
            RD_TRAP: pc_next_o = TRAP_VECTOR;
            default: begin
              if (misaligned(sel_tgt)) begin
                pc_next_o  = TRAP_VECTOR;
                misalign_o = 1'b1;
              end else begin
                pc_next_o = sel_tgt;
              end
            end
          endcase
        end
      end
      default: ;  // HALT: hold the PC, no request
    endcase
    if (rst_i) begin
      pc_next_o          = RESET_VECTOR;
      imem.imem_req_o    = 1'b0;
      imem.instr_valid_o = 1'b0;
      misalign_o         = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      halt_pend_q <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      if (accept && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      case (cur_st)
        ST_IDLE: state_q <= ST_FETCH;
        ST_FETCH: begin
          if (imem.imem_ready_i) begin
            // A halt seen during a stall takes effect once the fetch completes.
            if (halt_i || halt_pend_q) state_q <= ST_HALT;
            halt_pend_q <= 1'b0;
          end else if (halt_i) begin
            halt_pend_q <= 1'b1;
          end
        end
        default: if (resume_i || trap_i) state_q <= ST_FETCH;
      endcase
    end
  end

  assign state_o       = cur_st;
  assign fetch_count_o = fetch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam logic [63:0] RV = 64'h0;
  localparam logic [63:0] TV = 64'h100;
  localparam int          IB = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [63:0] pc_i;
  logic [63:0] pc_next_o;
  logic        branch_i, jump_i, trap_i, halt_i, resume_i;
  logic [63:0] branch_target_i, jump_target_i;
  logic [1:0]  state_o;
  logic        misalign_o;
  logic [31:0] fetch_count_o;

  pc_sequencer_if imem_if ();

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INSTR_BYTES(IB)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .imem            (imem_if),
    .pc_i            (pc_i),
    .pc_next_o       (pc_next_o),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .trap_i          (trap_i),
    .halt_i          (halt_i),
    .resume_i        (resume_i),
    .state_o         (state_o),
    .misalign_o      (misalign_o),
    .fetch_count_o   (fetch_count_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit follow   = 1'b0;
  logic [63:0] pc_hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 fetching, 2 halted. Pending redirect kind: 0 none,
  // 1 branch, 2 jump, 3 trap (bigger wins, later equal pulse replaces target).
  int          m_mode = 0;
  int          m_pk   = 0;
  logic [63:0] m_pt   = '0;
  bit          m_halt = 1'b0;
  longint      m_cnt  = 0;

  always @(negedge clk) begin
    int          bk;
    logic [63:0] bt;
    logic [63:0] e_pc;
    bit          e_req, e_val, e_mis;
    if (chk_en) begin
      chk("state_o", {62'd0, state_o}, 64'(m_mode));
      chk("fetch_count_o", {32'd0, fetch_count_o}, 64'(m_cnt));
      // Winner among the held redirect and this cycle's pulses.
      bk = m_pk; bt = m_pt;
      if (branch_i && bk <= 1) begin bk = 1; bt = branch_target_i; end
      if (jump_i   && bk <= 2) begin bk = 2; bt = jump_target_i;   end
      if (trap_i)              begin bk = 3; bt = TV;              end
      e_pc = pc_i; e_req = 0; e_val = 0; e_mis = 0;
      if (rst_i) begin
        e_pc = RV;
        m_mode = 0; m_pk = 0; m_pt = '0; m_halt = 0; m_cnt = 0;
      end else if (m_mode == 0) begin
        e_pc = RV;
        m_mode = 1; m_pk = bk; m_pt = bt;
      end else if (m_mode == 1) begin
        e_req = 1;
        if (!imem_if.imem_ready_i) begin
          m_pk = bk; m_pt = bt;
          if (halt_i) m_halt = 1;
        end else begin
          e_val = 1;
          if (bk == 0) e_pc = pc_i + 64'(IB);
          else if (bk == 3) e_pc = TV;
          else if (bt % 4 != 0) begin e_pc = TV; e_mis = 1; end
          else e_pc = bt;
          m_pk = 0; m_pt = '0;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          if (halt_i || m_halt) begin m_mode = 2; m_halt = 0; end
        end
      end else begin
        m_pk = bk; m_pt = bt;
        if (resume_i || trap_i) m_mode = 1;
      end
      chk("pc_next_o", pc_next_o, e_pc);
      chk("imem_req_o", 64'(imem_if.imem_req_o), 64'(e_req));
      chk("instr_valid_o", 64'(imem_if.instr_valid_o), 64'(e_val));
      chk("misalign_o", 64'(misalign_o), 64'(e_mis));
      if (e_req) chk("imem_addr_o", imem_if.imem_addr_o, pc_i);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(negedge clk);
  endtask

  // Finish the cycle: model the external PC register, then drop pulses.
  task automatic adv();
    pc_hold = pc_next_o;
    @(posedge clk);
    #1;
    if (follow) pc_i = pc_hold;
    branch_i = 0; jump_i = 0; trap_i = 0; halt_i = 0; resume_i = 0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_i = 1; pc_i = '0; imem_if.imem_ready_i = 0;
    branch_i = 0; jump_i = 0; trap_i = 0; halt_i = 0; resume_i = 0;
    branch_target_i = '0; jump_target_i = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;

    settle(); chk("lit_rst_pc_next", pc_next_o, 64'h0); chk("lit_rst_count", 64'(fetch_count_o), 0); adv();

    // Sequential fetch with the PC register following pc_next_o.
    rst_i = 0; follow = 1; imem_if.imem_ready_i = 1;
    settle(); chk("lit_idle_state", 64'(state_o), 0); adv();
    for (int i = 0; i < 4; i++) begin
      settle(); chk($sformatf("lit_seq_addr%0d", i), imem_if.imem_addr_o, 64'(i * 4)); adv();
    end

    // Stall with branch then jump pending; jump wins on acceptance.
    follow = 0; pc_i = 64'h40; imem_if.imem_ready_i = 0;
    branch_i = 1; branch_target_i = 64'h80;
    settle(); chk("lit_count4", 64'(fetch_count_o), 4); chk("lit_stall1", pc_next_o, 64'h40); adv();
    jump_i = 1; jump_target_i = 64'h200;
    settle(); chk("lit_stall2", pc_next_o, 64'h40); adv();
    settle(); chk("lit_stall3", pc_next_o, 64'h40); adv();
    imem_if.imem_ready_i = 1;
    settle(); chk("lit_redirect", pc_next_o, 64'h200); adv();
    pc_i = 64'h200;
    settle(); chk("lit_pend_empty", pc_next_o, 64'h204); adv();

    // Misaligned jump target.
    pc_i = 64'h300; jump_i = 1; jump_target_i = 64'h102;
    settle(); chk("lit_mis_pc", pc_next_o, 64'h100); chk("lit_mis_pulse", 64'(misalign_o), 1); adv();
    pc_i = 64'h100;
    settle(); chk("lit_mis_clear", 64'(misalign_o), 0); adv();

    // Halt requested during a stall, then resume.
    pc_i = 64'h10; imem_if.imem_ready_i = 0; halt_i = 1;
    settle(); chk("lit_halt_stall_valid", 64'(imem_if.instr_valid_o), 0); adv();
    settle(); adv();
    imem_if.imem_ready_i = 1;
    settle(); chk("lit_halt_accept_valid", 64'(imem_if.instr_valid_o), 1); chk("lit_halt_accept_pc", pc_next_o, 64'h14); adv();
    pc_i = 64'h14;
    settle(); chk("lit_halted", 64'(state_o), 2); chk("lit_halted_req", 64'(imem_if.imem_req_o), 0); adv();
    resume_i = 1;
    settle(); chk("lit_resume_cycle", 64'(state_o), 2); adv();
    settle(); chk("lit_resumed", 64'(state_o), 1); chk("lit_resumed_addr", imem_if.imem_addr_o, 64'h14); adv();

    // Trap while halted is held and applied at the next acceptance.
    halt_i = 1; pc_i = 64'h18;
    settle(); adv();
    pc_i = 64'h1c; trap_i = 1;
    settle(); chk("lit_halt_trap_state", 64'(state_o), 2); adv();
    settle(); chk("lit_halt_trap_apply", pc_next_o, TV); adv();

    // 64-bit wrap.
    pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    settle(); chk("lit_wrap", pc_next_o, 64'h0); adv();

    // Reset mid-stall with a pending trap.
    pc_i = 64'h500; imem_if.imem_ready_i = 0; trap_i = 1;
    settle(); adv();
    rst_i = 1;
    settle(); chk("lit_rst_stall_valid", 64'(imem_if.instr_valid_o), 0); chk("lit_rst_stall_pc", pc_next_o, RV); adv();
    rst_i = 0; imem_if.imem_ready_i = 1; follow = 1;
    settle(); chk("lit_post_rst_idle", 64'(state_o), 0); adv();
    settle(); chk("lit_post_rst_addr", imem_if.imem_addr_o, RV); chk("lit_post_rst_next", pc_next_o, RV + 64'(IB)); adv();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameters: RESET_VECTOR, default 64'h0, first fetch address; TRAP_VECTOR, default 64'h100, trap/misalign target; INSTR_BYTES, default 4, sequential increment.
REQ-002 Port: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_i  in  1  reset, synchronous, active-high.
REQ-004 Port: pc_i  in  64  current PC from the external program-counter register.
REQ-005 Port: pc_next_o  out  64  next value loaded into the program-counter register every cycle.
REQ-006 Port: imem_req_o  out  1  instruction fetch request; imem_addr_o  out  64  fetch address.
REQ-007 Port: imem_ready_i  in  1  instruction memory accepts/returns the fetch this cycle.
REQ-008 Port: instr_valid_o  out  1  fetch completes this cycle.
REQ-009 Port: branch_i  in  1  plus branch_target_i  in  64; jump_i  in  1  plus jump_target_i  in  64; trap_i  in  1; all single-cycle redirect pulses.
REQ-010 Port: halt_i  in  1  halt request; resume_i  in  1  leave halt.
REQ-011 Port: state_o  out  2  FSM state; misalign_o  out  1  misaligned-target pulse; fetch_count_o  out  32  completed fetches.

Function
REQ-012 The FSM SHALL have states IDLE=0, FETCH=1, HALT=2; encoding 3 is unreachable and SHALL decode as IDLE.
REQ-013 In IDLE, imem_req_o=0 and pc_next_o=RESET_VECTOR; the next cycle SHALL always be FETCH.
REQ-014 In FETCH, imem_req_o=1 and imem_addr_o=pc_i, combinationally.
REQ-015 In FETCH with imem_ready_i=0, pc_next_o SHALL equal pc_i (stall), and instr_valid_o SHALL be 0.
REQ-016 In FETCH with imem_ready_i=1, instr_valid_o SHALL be 1 in the same cycle, and pc_next_o SHALL be the selected next PC.
REQ-017 Next-PC priority: trap > jump > branch > pc_i+INSTR_BYTES. This is evaluated over the current-cycle pulses together with the pending redirect.
REQ-018 A redirect pulse arriving while imem_ready_i=0 or in HALT SHALL be held in a pending register. The pending register keeps only the highest-priority redirect; an equal-priority later pulse overwrites the target.
REQ-019 The pending redirect SHALL clear in the cycle it is applied.
REQ-020 A jump or branch target with low two bits nonzero SHALL select TRAP_VECTOR instead and pulse misalign_o=1 in the cycle it is applied.
REQ-021 All 64-bit PC arithmetic SHALL wrap modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC+4 yields 0.
REQ-022 halt_i=1 in a FETCH cycle with imem_ready_i=1 SHALL complete that fetch and enter HALT next cycle. halt_i while stalled SHALL be remembered until that acceptance.
REQ-023 In HALT, imem_req_o=0 and pc_next_o=pc_i. resume_i=1 or trap_i=1 SHALL return to FETCH next cycle, with pending redirects applied at the next acceptance.
REQ-024 fetch_count_o SHALL increment on each instr_valid_o=1 cycle and saturate at 32'hFFFF_FFFF.

Reset
REQ-025 While rst_i=1, pc_next_o SHALL be RESET_VECTOR, and imem_req_o, instr_valid_o and misalign_o SHALL be 0.
REQ-026 After an active rst_i edge, state SHALL be IDLE, the pending register and halt memory SHALL be empty, and fetch_count_o SHALL be 0.
REQ-027 Reset asserted mid-stall SHALL discard the outstanding fetch and any pending redirect without raising instr_valid_o.

Structure
REQ-028 Package pc_ctrl_pkg SHALL hold the state enum, redirect-kind enum (NONE/BRANCH/JUMP/TRAP), and default RESET_VECTOR/TRAP_VECTOR/INSTR_BYTES constants.
REQ-029 Sub-module pc_redirect_latch SHALL implement the pending priority register (REQ-018/019), instantiated once.

Verification
REQ-030 Reset, then ready tied 1 for 4 cycles with pc_i following pc_next_o -> addresses 0, 4, 8, 12; fetch_count_o=4.
REQ-031 At pc 0x40, ready=0 for 3 cycles with branch_i to 0x80 in cycle 1 and jump_i to 0x200 in cycle 2, then ready=1 -> pc_next_o 0x40 while stalled, then 0x200; pending empty afterwards.
REQ-032 Ready=1 with jump_i target 0x102 -> pc_next_o=0x100 (TRAP_VECTOR) and misalign_o=1 for one cycle.
REQ-033 halt_i during a stall at pc 0x10, ready=1 two cycles later -> instr_valid_o once, then HALT with req=0. resume_i then returns to FETCH at 0x14.
REQ-034 pc_i=64'hFFFF_FFFF_FFFF_FFFC with ready=1 -> pc_next_o=0. rst_i=1 mid-stall with a pending trap -> IDLE, no instr_valid_o, next fetch at RESET_VECTOR.
